// File: rtl/mem_line_responder_pkg.sv
// Shared widths, FSM encoding and line-width helper for mem_line_responder.
// The optional address-range check is enabled with `define MEM_ADDR_CHECK_EN.
package mem_line_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int line_w(input int line_words);
    return WORD_W * line_words;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Register backing store: byte-enabled write port and a combinational whole-line
// read that already reflects a write landing on the same edge (write-first).
module mem_word_array
  import mem_line_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_WORDS  = 4,
  parameter int IDX_W       = $clog2(DEPTH_WORDS),
  parameter int OFF_W       = $clog2(LINE_WORDS)
) (
  input  logic                          clk_i,
  input  logic                          wr_en_i,
  input  logic [IDX_W-1:0]              wr_idx_i,
  input  logic [WORD_W-1:0]             wr_data_i,
  input  logic [BE_W-1:0]               wr_sel_i,
  input  logic [IDX_W-OFF_W-1:0]        rd_line_i,
  output logic [line_w(LINE_WORDS)-1:0] rd_line_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_sel_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_word
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;

    assign idx = {rd_line_i, OFF_W'(i)};

    // Merge the in-flight write so a snapshot taken on this edge sees it.
    always_comb begin
      word = mem_q[idx];
      if (wr_en_i && (wr_idx_i == idx)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (wr_sel_i[b]) word[8*b +: 8] = wr_data_i[8*b +: 8];
        end
      end
    end

    assign rd_line_o[WORD_W*i +: WORD_W] = word;
  end

endmodule

// File: rtl/mem_line_responder.sv
// Multi-cycle data-side responder: line reads after RD_LATENCY cycles, byte-enabled
// single-cycle writes. `define MEM_ADDR_CHECK_EN adds out-of-range flagging on mem_err_o.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_WORDS  = 4,
  parameter int RD_LATENCY  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          mem_rd_en_i,
  input  logic [ADDR_W-1:0]             mem_rd_addr_i,
  output logic [line_w(LINE_WORDS)-1:0] mem_rd_data_o,
  output logic                          mem_rd_valid_o,
  output logic                          mem_busy_o,
  input  logic                          mem_wr_en_i,
  input  logic [ADDR_W-1:0]             mem_wr_addr_i,
  input  logic [WORD_W-1:0]             mem_wr_data_i,
  input  logic [BE_W-1:0]               mem_wr_sel_i,
  output logic                          mem_err_o
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = line_w(LINE_WORDS);
  localparam int CNT_W  = $clog2(RD_LATENCY + 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;
  logic [LINE_W-1:0] data_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] array_line;
  logic [LINE_W-1:0] snap_line;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_en_eff;
  logic              accept;
  logic              resp_set;

  assign rd_idx = mem_rd_addr_i[IDX_W+1:2];
  assign wr_idx = mem_wr_addr_i[IDX_W+1:2];

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LINE_WORDS  (LINE_WORDS)
  ) u_array (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_eff),
    .wr_idx_i  (wr_idx),
    .wr_data_i (mem_wr_data_i),
    .wr_sel_i  (mem_wr_sel_i),
    .rd_line_i (rd_idx[IDX_W-1:OFF_W]),
    .rd_line_o (array_line)
  );

  // accept: request seen in IDLE; resp_set: this edge moves the FSM into RESP.
  assign accept   = (state_q == ST_IDLE) && mem_rd_en_i;
  assign resp_set = (accept && (RD_LATENCY == 1)) ||
                    ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));

`ifdef MEM_ADDR_CHECK_EN
  logic rd_oor;
  logic wr_oor;
  logic rd_oor_q;
  logic err_q;
  logic unused_addr_bits;

  assign rd_oor           = |mem_rd_addr_i[ADDR_W-1:IDX_W+2];
  assign wr_oor           = |mem_wr_addr_i[ADDR_W-1:IDX_W+2];
  assign wr_en_eff        = mem_wr_en_i && !wr_oor;
  assign snap_line        = rd_oor ? '0 : array_line;
  assign unused_addr_bits = ^{mem_rd_addr_i[1:0], mem_wr_addr_i[1:0]};

  // Error is raised for one cycle after a dropped write, or for the RESP cycle of an out-of-range read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) rd_oor_q <= rd_oor;
      err_q <= (mem_wr_en_i && wr_oor) ||
               (resp_set && (accept ? rd_oor : rd_oor_q));
    end
  end

  assign mem_err_o = err_q;
`else
  logic unused_addr_bits;

  assign wr_en_eff        = mem_wr_en_i;
  assign snap_line        = array_line;
  assign unused_addr_bits = ^{mem_rd_addr_i[ADDR_W-1:IDX_W+2], mem_rd_addr_i[1:0],
                              mem_wr_addr_i[ADDR_W-1:IDX_W+2], mem_wr_addr_i[1:0]};
  assign mem_err_o        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      line_q  <= '0;
    end else begin
      valid_q <= resp_set;
      if (resp_set) data_q <= accept ? snap_line : line_q;
      case (state_q)
        ST_IDLE: begin
          if (mem_rd_en_i) begin
            line_q  <= snap_line;
            cnt_q   <= CNT_W'(RD_LATENCY - 1);
            state_q <= (RD_LATENCY > 1) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_busy_o     = (state_q != ST_IDLE);
  assign mem_rd_valid_o = valid_q;
  assign mem_rd_data_o  = data_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a RD_LATENCY=3 and a RD_LATENCY=1 instance share
// one write bus; expected lines go into per-instance queues and are popped on mem_rd_valid.
module tb_mem_line_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en;
  logic         rd1_en;
  logic [31:0]  rd_addr;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;
  logic [3:0]   wr_sel;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         busy;
  logic         err;
  logic [127:0] rd1_data;
  logic         rd1_valid;
  logic         busy1;
  logic         err1;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  logic prev0  = 1'b0;
  logic prev1  = 1'b0;

  // {err, line} per expected response
  logic [128:0] exp_q[$];
  logic [128:0] exp1_q[$];
  logic [31:0]  model_mem [1024];

  always #5 clk = ~clk;

  mem_line_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LINE_WORDS(4), .RD_LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_rd_en_i(rd_en), .mem_rd_addr_i(rd_addr),
    .mem_rd_data_o(rd_data), .mem_rd_valid_o(rd_valid), .mem_busy_o(busy),
    .mem_wr_en_i(wr_en), .mem_wr_addr_i(wr_addr), .mem_wr_data_i(wr_data), .mem_wr_sel_i(wr_sel),
    .mem_err_o(err)
  );

  mem_line_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LINE_WORDS(4), .RD_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .mem_rd_en_i(rd1_en), .mem_rd_addr_i(rd_addr),
    .mem_rd_data_o(rd1_data), .mem_rd_valid_o(rd1_valid), .mem_busy_o(busy1),
    .mem_wr_en_i(wr_en), .mem_wr_addr_i(wr_addr), .mem_wr_data_i(wr_data), .mem_wr_sel_i(wr_sel),
    .mem_err_o(err1)
  );

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic is_oor(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return |a[31:12];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [128:0] model_line(input logic [31:0] a);
    logic [9:0] base;
    base = {a[11:4], 2'b00};
    if (is_oor(a)) return {1'b1, 128'b0};
    return {1'b0, model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [9:0] idx;
    idx = a[11:2];
    if (!is_oor(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // Drives one cycle starting just after a rising edge; returns #1 after the next edge.
  task automatic step(input logic r0, input logic r1, input logic [31:0] ra,
                      input logic acc0, input logic acc1,
                      input logic w, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws);
    rd_en = r0; rd1_en = r1; rd_addr = ra;
    wr_en = w; wr_addr = wa; wr_data = wd; wr_sel = ws;
    if (w) model_write(wa, wd, ws);
    if (acc0) exp_q.push_back(model_line(ra));
    if (acc1) exp1_q.push_back(model_line(ra));
    @(posedge clk); #1;
    rd_en = 1'b0; rd1_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(0, 0, 32'h0, 0, 0, 1, a, d, s);
  endtask

  task automatic read_and_check(input logic [31:0] a);
    step(1, 0, a, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      chk("rd_busy", 129'(busy), 129'(k < 3));
      chk("rd_valid", 129'(rd_valid), 129'(k == 2));
      if (k < 3) idle();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid === 1'b1) begin
        chk("valid_consec", 129'(prev0), 129'(0));
        chk("sb_has_item", 129'(exp_q.size() != 0), 129'(1));
        if (exp_q.size() != 0) chk("rd_line", {err, rd_data}, exp_q.pop_front());
      end
      prev0 = rd_valid;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd1_valid === 1'b1) begin
        chk("valid_consec_l1", 129'(prev1), 129'(0));
        chk("sb_has_item_l1", 129'(exp1_q.size() != 0), 129'(1));
        if (exp1_q.size() != 0) chk("rd_line_l1", {err1, rd1_data}, exp1_q.pop_front());
      end
      prev1 = rd1_valid;
    end
  end

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd1_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 129'(busy), 129'(0));
    chk("reset_valid", 129'(rd_valid), 129'(0));
    chk("reset_data", 129'(rd_data), 129'(0));
    chk("reset_err", 129'(err), 129'(0));
    chk("reset_busy_l1", 129'(busy1), 129'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 24; i++) wr(32'(i * 4), $urandom, 4'hF);

    // Basic line read
    wr(32'h40, 32'h11111111, 4'hF);
    wr(32'h44, 32'h22222222, 4'hF);
    wr(32'h48, 32'h33333333, 4'hF);
    wr(32'h4C, 32'h44444444, 4'hF);
    read_and_check(32'h48);
    chk("line_48", 129'(rd_data), 129'({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}));
    idle();
    chk("data_hold", 129'(rd_data), 129'({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}));

    // Byte enables, and an all-zero select as a no-op
    wr(32'h40, 32'h0, 4'hF);
    wr(32'h40, 32'hAABBCCDD, 4'b0101);
    wr(32'h4C, 32'hFFFFFFFF, 4'h0);
    read_and_check(32'h40);
    chk("partial_word0", 129'(rd_data[31:0]), 129'(32'h00BB00DD));
    chk("sel0_word3", 129'(rd_data[127:96]), 129'(32'h44444444));

    // Same-edge write is captured; later write in WAIT is not
    step(1, 0, 32'h40, 1, 0, 1, 32'h44, 32'hDEADBEEF, 4'hF);
    wr(32'h44, 32'h0, 4'hF);
    idle();
    chk("wfirst_valid", 129'(rd_valid), 129'(1));
    idle();
    chk("wfirst_word1", 129'(rd_data[63:32]), 129'(32'hDEADBEEF));

    // Back-to-back requests, RD_LATENCY=3: one accept every 4 cycles
    for (int i = 0; i < 12; i++) begin
      logic r;
      r = (i <= 8);
      step(r, 0, ((i / 4) % 2 == 0) ? 32'h40 : 32'h50, r && (i % 4 == 0), 0,
           0, 32'h0, 32'h0, 4'h0);
      chk("b2b_busy", 129'(busy), 129'(i % 4 != 3));
      chk("b2b_valid", 129'(rd_valid), 129'(i % 4 == 2));
    end

    // Back-to-back requests, RD_LATENCY=1: one accept every 2 cycles
    for (int i = 0; i < 8; i++) begin
      step(0, (i < 7), 32'h50, 0, (i % 2 == 0), 0, 32'h0, 32'h0, 4'h0);
      chk("b2b_busy_l1", 129'(busy1), 129'(i % 2 == 0));
      chk("b2b_valid_l1", 129'(rd1_valid), 129'(i % 2 == 0));
    end

    // Reset during WAIT abandons the read
    step(1, 0, 32'h50, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    exp_q.delete();
    idle();
    chk("midrst_busy", 129'(busy), 129'(0));
    chk("midrst_valid", 129'(rd_valid), 129'(0));
    chk("midrst_data", 129'(rd_data), 129'(0));
    chk("midrst_err", 129'(err), 129'(0));
    rst = 1'b0;
    repeat (3) idle();
    read_and_check(32'h50);

    // Address beyond the store: dropped and flagged with the check, wrapped without it
    wr(32'h1000, 32'h12345678, 4'hF);
    chk("wr_err_pulse", 129'(err), 129'(is_oor(32'h1000)));
    idle();
    chk("wr_err_clear", 129'(err), 129'(0));
    read_and_check(32'h1000);
    read_and_check(32'h0);

    repeat (3) idle();
    chk("sb_drained", 129'(exp_q.size()), 129'(0));
    chk("sb_drained_l1", 129'(exp1_q.size()), 129'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
Data-side memory responder for the core's data interface. The core issues cache-line reads and partial word writes; this block services them.
- Reads return a full cache line after a fixed, parameterised latency, qualified by a valid pulse and guarded by a busy flag.
- Writes are single-cycle and use per-byte enables.
- Sits at SoC level between the core's mem_rd_*/mem_wr_* ports and a register-array backing store.
- Intended as the multi-cycle replacement for the single-cycle data RAM.

Parameters:
ADDR_W, 32, byte-address width
DEPTH_WORDS, 1024, backing-store depth in 32-bit words (power of 2)
LINE_WORDS, 4, words per cache line (power of 2, >=2)
RD_LATENCY, 3, cycles from read accept to rd_valid (>=1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
mem_rd_en  in  1  read request; accepted when high and mem_busy low
mem_rd_addr  in  ADDR_W  byte address of any byte inside the requested line
mem_rd_data  out  32*LINE_WORDS  returned line; word i at bits [32*i+31:32*i]
mem_rd_valid  out  1  one-cycle pulse; mem_rd_data is valid in this cycle
mem_busy  out  1  high while a read is outstanding
mem_wr_en  in  1  write strobe, always accepted
mem_wr_addr  in  ADDR_W  byte address; bits [1:0] ignored
mem_wr_data  in  32  write word
mem_wr_sel  in  4  byte enables; bit b writes bits [8b+7:8b]
mem_err  out  1  address-range error flag (optional feature only, else tied 0)

Behaviour:
- Reset (rst high at an edge): state IDLE, counter 0, mem_rd_valid 0, mem_busy 0, mem_rd_data 0, mem_err 0.
  - Store contents are not reset.
  - Reset mid-read abandons the read with no valid pulse.
- Word index is addr[ADDR_W-1:2] modulo DEPTH_WORDS. Line base is the word index with its low log2(LINE_WORDS) bits cleared. Lines never straddle the wrap point.
- Write: on an edge with mem_wr_en=1, the enabled bytes of the addressed word are updated. Writes are accepted in any state. mem_wr_sel=0 makes the write a no-op.
- FSM states: IDLE, WAIT, RESP. mem_busy = (state != IDLE).
  - IDLE, mem_rd_en=1 at an edge (accept): snapshot all LINE_WORDS words of the line into the line register. A same-edge write to that line is included in the snapshot (write-first). Load counter with RD_LATENCY-1. Next state is WAIT if RD_LATENCY>1, else RESP.
  - WAIT: decrement counter each edge; go to RESP when counter reaches 1. mem_rd_en is ignored. Writes during WAIT update the store but not the snapshot.
  - RESP: mem_rd_valid=1 and mem_rd_data drives the snapshot. Next state is IDLE. A request in this cycle is not accepted.
- Timing: accept at edge T, so mem_rd_valid is high in the cycle after edge T+RD_LATENCY-1, i.e. RD_LATENCY cycles after the request cycle. Maximum throughput is one line per RD_LATENCY+1 cycles.
- mem_rd_data holds its last line between responses.
- mem_rd_valid is never high for two consecutive cycles.

Optional Feature:
MEM_ADDR_CHECK_EN
- Defined:
  - An access whose word index is >= DEPTH_WORDS (any nonzero address bit above the index range) is flagged out of range.
  - An out-of-range read still goes through the normal FSM, but returns an all-zero line with mem_err=1 during its RESP cycle.
  - An out-of-range write is dropped, and mem_err pulses for one cycle after that edge.
  - mem_err is otherwise 0.
- Undefined: addresses wrap modulo DEPTH_WORDS, mem_err is constant 0, and no check logic is built.

Decomposition:
- Shared package/defines: word width 32, byte-enable width 4, FSM state encodings, and a line-width helper (32*LINE_WORDS).
- Existing `CacheLine`/`DataAddrBus` macros are to be reused where the widths match.
- One natural sub-module, mem_word_array: the register store with a byte-enabled write port and a LINE_WORDS-wide combinational line read.

Test Plan:
- Reset, then write 0x11111111..0x44444444 to addresses 0x40..0x4C and read 0x48 with RD_LATENCY=3 -> mem_busy high for 3 cycles, then a single mem_rd_valid pulse with line {0x44444444,0x33333333,0x22222222,0x11111111}.
- Write 0xAABBCCDD sel=4'b0101 over 0x00000000 at 0x40, then read -> word0 = 0x00BB00DD.
- Same-edge read 0x40 and write 0x44=0xDEADBEEF -> returned word1 = 0xDEADBEEF. Then write 0x44=0x0 during WAIT -> response still 0xDEADBEEF.
- mem_rd_en held high continuously with RD_LATENCY=1 -> valid every 2nd cycle. With RD_LATENCY=3 -> every 4th cycle, and requests during busy are not accepted.
- Assert rst in the WAIT cycle -> no mem_rd_valid; next cycle all outputs are 0 and a new request is serviced normally.
- With MEM_ADDR_CHECK_EN, DEPTH_WORDS=1024, read 0x00001000 -> zero line with mem_err=1 on the valid cycle. Write to 0x00001000 -> store unchanged (read 0x0 confirms).
